// File: rtl/sp_ram_be_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_be_ctrl
//  Description : Single-port synchronous RAM with a valid/ready request port,
//                per-byte write enables, selectable read-during-write result,
//                optional output register and a hardware clear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_be_ctrl #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 16,
    parameter int BYTE_WIDTH     = 8,
    parameter int OUT_REG        = 0,
    parameter int WR_MODE        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    input  logic                             i_req_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_req_be,
    input  logic [ADDR_WIDTH-1:0]            i_req_addr,
    input  logic [DATA_WIDTH-1:0]            i_req_wdata,
    output logic                             o_rsp_valid,
    output logic [DATA_WIDTH-1:0]            o_rsp_rdata,
    output logic                             o_rsp_err,
    input  logic                             i_clr_start,
    output logic                             o_busy
);

    localparam int c_NB = DATA_WIDTH / BYTE_WIDTH;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t                c_RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    // One extra bit so the bound is representable when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   c_DEPTH     = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_addr;
    logic [ADDR_WIDTH-1:0]   w_clr_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_accept;
    logic                    w_in_range;
    logic [DATA_WIDTH-1:0]   w_old;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [DATA_WIDTH-1:0]   w_rsp_data;

    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;

    assign w_accept   = i_req_valid & o_req_ready;
    assign w_in_range = ({1'b0, i_req_addr} < c_DEPTH);
    assign w_old      = w_in_range ? r_mem[i_req_addr] : '0;

    // Merge enabled write lanes over the currently stored word.
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < c_NB; i++) begin
            if (i_req_be[i]) begin
                w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = i_req_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Response word: zero when out of range, merged word for write-first writes.
    always_comb begin
        w_rsp_data = w_old;
        if (!w_in_range) begin
            w_rsp_data = '0;
        end else if (i_req_we && (WR_MODE != 0)) begin
            w_rsp_data = w_merged;
        end
    end

    // FSM state and clear-address register; reset restarts any clear from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_RST_STATE;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // Next-state logic; ready depends only on state and clr_start (clear wins).
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        o_req_ready    = 1'b0;
        o_busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = rst_n & ~i_clr_start;
                if (i_clr_start) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            S_CLEAR: begin
                o_busy = 1'b1;
                if (r_clr_addr == c_LAST_ADDR) begin
                    w_state_nxt    = S_IDLE;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + ADDR_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    // Storage array: clear engine owns the port while busy, else accepted writes.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_addr] <= '0;
        end else if (w_accept && i_req_we && w_in_range) begin
            r_mem[i_req_addr] <= w_merged;
        end
    end

    // First response stage: pulse per accepted request, data held between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_rdata <= w_rsp_data;
                r_rsp_err   <= ~w_in_range;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_out_valid;
            logic [DATA_WIDTH-1:0] r_out_rdata;
            logic                  r_out_err;

            // Extra pipeline stage adding one cycle of response latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_valid <= 1'b0;
                    r_out_rdata <= '0;
                    r_out_err   <= 1'b0;
                end else begin
                    r_out_valid <= r_rsp_valid;
                    if (r_rsp_valid) begin
                        r_out_rdata <= r_rsp_rdata;
                        r_out_err   <= r_rsp_err;
                    end
                end
            end

            assign o_rsp_valid = r_out_valid;
            assign o_rsp_rdata = r_out_rdata;
            assign o_rsp_err   = r_out_err;
        end else begin : g_no_out_reg
            assign o_rsp_valid = r_rsp_valid;
            assign o_rsp_rdata = r_rsp_rdata;
            assign o_rsp_err   = r_rsp_err;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_be_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_ram_be_ctrl
//  Description : Scoreboard bench for sp_ram_be_ctrl. Two instances share one
//                stimulus stream: A = DEPTH 16, OUT_REG 0, READ_FIRST;
//                B = DEPTH 12, OUT_REG 1, WRITE_FIRST.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_be_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_be;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        clr_start;

    logic        a_ready, a_valid, a_err, a_busy;
    logic [31:0] a_rdata;
    logic        b_ready, b_valid, b_err, b_busy;
    logic [31:0] b_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sp_ram_be_ctrl #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .BYTE_WIDTH(8),
        .OUT_REG(0), .WR_MODE(0), .CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(a_ready), .i_req_we(req_we),
        .i_req_be(req_be), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(a_valid), .o_rsp_rdata(a_rdata), .o_rsp_err(a_err),
        .i_clr_start(clr_start), .o_busy(a_busy)
    );

    sp_ram_be_ctrl #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12), .BYTE_WIDTH(8),
        .OUT_REG(1), .WR_MODE(1), .CLEAR_ON_RESET(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(b_ready), .i_req_we(req_we),
        .i_req_be(req_be), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(b_valid), .o_rsp_rdata(b_rdata), .o_rsp_err(b_err),
        .i_clr_start(clr_start), .o_busy(b_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor A: pops one expectation per response pulse.
    always @(negedge clk) begin : m_a
        exp_t e;
        if (rst_n && a_valid) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL A unexpected response: got data 0x%0h with no request pending", a_rdata);
            end else begin
                e = qa.pop_front();
                check("A rdata",   {32'h0, a_rdata}, {32'h0, e.data});
                check("A err",     {63'h0, a_err},   {63'h0, e.err});
                check("A latency", 64'(cyc),         64'(e.cyc));
            end
        end
    end

    // Monitor B: same, for the registered-output instance.
    always @(negedge clk) begin : m_b
        exp_t e;
        if (rst_n && b_valid) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL B unexpected response: got data 0x%0h with no request pending", b_rdata);
            end else begin
                e = qb.pop_front();
                check("B rdata",   {32'h0, b_rdata}, {32'h0, e.data});
                check("B err",     {63'h0, b_err},   {63'h0, e.err});
                check("B latency", 64'(cyc),         64'(e.cyc));
            end
        end
    end

    // Present one request for one cycle and queue both expected responses.
    task automatic issue(input logic we, input logic [3:0] be, input logic [3:0] addr,
                         input logic [31:0] wd,
                         input logic [31:0] ea, input logic ea_err,
                         input logic [31:0] eb, input logic eb_err);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        check("A ready", {63'h0, a_ready}, 64'h1);
        check("B ready", {63'h0, b_ready}, 64'h1);
        @(posedge clk);
        #1;
        qa.push_back('{ea, ea_err, cyc});
        qb.push_back('{eb, eb_err, cyc + 1});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
            clr_start = 1'b0;
        end
    endtask

    // Count cycles with busy high over a fixed window; optionally pulse clr_start.
    task automatic count_busy(output int ca, output int cb, output int viol, input int inj_at);
        ca   = 0;
        cb   = 0;
        viol = 0;
        for (int i = 0; i < 30; i++) begin
            clr_start = (i == inj_at);
            #1;
            if (a_busy) ca++;
            if (b_busy) cb++;
            if ((a_busy && a_ready) || (b_busy && b_ready)) viol++;
            @(negedge clk);
        end
        clr_start = 1'b0;
    endtask

    function automatic logic [31:0] img(input int a);
        case (a)
            3:       return 32'hDE22BE44;
            5:       return 32'h55555555;
            default: return 32'h0;
        endcase
    endfunction

    initial begin : stim
        int ca, cb, viol;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 4'h0;
        req_wdata = 32'h0;
        clr_start = 1'b0;

        // Values held while reset is asserted.
        repeat (3) @(negedge clk);
        #1;
        check("reset A ready", {63'h0, a_ready}, 64'h0);
        check("reset A valid", {63'h0, a_valid}, 64'h0);
        check("reset A rdata", {32'h0, a_rdata}, 64'h0);
        check("reset A err",   {63'h0, a_err},   64'h0);
        check("reset A busy",  {63'h0, a_busy},  64'h1);
        check("reset B valid", {63'h0, b_valid}, 64'h0);
        check("reset B rdata", {32'h0, b_rdata}, 64'h0);
        check("reset B busy",  {63'h0, b_busy},  64'h1);

        // Automatic clear after reset release: DEPTH busy cycles.
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(ca, cb, viol, -1);
        check("post-reset A busy cycles", 64'(ca), 64'd16);
        check("post-reset B busy cycles", 64'(cb), 64'd12);
        check("post-reset ready while busy", 64'(viol), 64'd0);

        // Every address reads zero; B reports addresses 12..15 out of range.
        for (int a = 0; a < 16; a++) begin
            issue(1'b0, 4'hF, 4'(a), 32'h0, 32'h0, 1'b0, 32'h0, (a >= 12));
        end

        // Byte-lane merge, back-to-back write/write/read on addr 3.
        issue(1'b1, 4'b1111, 4'd3, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b0);
        issue(1'b1, 4'b0101, 4'd3, 32'h11223344, 32'hDEADBEEF, 1'b0, 32'hDE22BE44, 1'b0);
        issue(1'b0, 4'b0000, 4'd3, 32'h0,        32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0);

        // Read-first versus write-first response on addr 5.
        issue(1'b1, 4'b1111, 4'd5, 32'hAAAAAAAA, 32'h00000000, 1'b0, 32'hAAAAAAAA, 1'b0);
        issue(1'b1, 4'b1111, 4'd5, 32'h55555555, 32'hAAAAAAAA, 1'b0, 32'h55555555, 1'b0);

        // Addr 13: in range for A, out of range for B.
        issue(1'b1, 4'b1111, 4'd13, 32'hCAFEF00D, 32'h00000000, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 4'b0000, 4'd13, 32'h0,        32'hCAFEF00D, 1'b0, 32'h0, 1'b1);
        for (int a = 0; a < 12; a++) begin
            issue(1'b0, 4'h0, 4'(a), 32'h0, img(a), 1'b0, img(a), 1'b0);
        end

        // Write with no lanes enabled is a no-op that still responds.
        issue(1'b1, 4'b0000, 4'd3, 32'h00000000, 32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0);
        issue(1'b0, 4'b0000, 4'd3, 32'h0,        32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0);

        // Read in flight, then clr_start with a colliding request: clear wins.
        issue(1'b0, 4'b0000, 4'd3, 32'h0, 32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd5;
        clr_start = 1'b1;
        #1;
        check("clr collision A ready", {63'h0, a_ready}, 64'h0);
        check("clr collision B ready", {63'h0, b_ready}, 64'h0);
        @(negedge clk);
        req_valid = 1'b0;
        count_busy(ca, cb, viol, 4);
        check("clear A busy cycles", 64'(ca), 64'd16);
        check("clear B busy cycles", 64'(cb), 64'd12);
        check("clear ready while busy", 64'(viol), 64'd0);
        issue(1'b0, 4'h0, 4'd3, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 4'h0, 4'd5, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Reset during a clear restarts it from address 0.
        issue(1'b1, 4'b1111, 4'd10, 32'h12345678, 32'h0, 1'b0, 32'h12345678, 1'b0);
        issue(1'b1, 4'b1111, 4'd2,  32'h0BADCAFE, 32'h0, 1'b0, 32'h0BADCAFE, 1'b0);
        idle(3);
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort A busy",  {63'h0, a_busy},  64'h1);
        check("abort A ready", {63'h0, a_ready}, 64'h0);
        check("abort B valid", {63'h0, b_valid}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(ca, cb, viol, -1);
        check("restart A busy cycles", 64'(ca), 64'd16);
        check("restart B busy cycles", 64'(cb), 64'd12);
        check("restart ready while busy", 64'(viol), 64'd0);
        issue(1'b0, 4'h0, 4'd10, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 4'h0, 4'd2,  32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 4'h0, 4'd15, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Every queued response must have been delivered.
        idle(4);
        #1;
        check("A responses outstanding", 64'(qa.size()), 64'd0);
        check("B responses outstanding", 64'(qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sp_ram_be_ctrl.md
# sp_ram_be_ctrl

Parametrised single-port synchronous RAM with a valid/ready request port, per-byte write enables, selectable read-during-write mode, an optional output register stage and a hardware memory-clear state machine. It is the next-generation single-port storage block for the design. Separate write and read data buses replace the bidirectional bus. Each accepted request returns exactly one response, so the block can sit directly behind a request pipeline without external sequencing.

## Interface
- ADDR_WIDTH, 4: address bits.
- DATA_WIDTH, 32: word width; must be a multiple of BYTE_WIDTH.
- DEPTH, 16: number of words; must satisfy DEPTH ≤ 2^ADDR_WIDTH.
- BYTE_WIDTH, 8: bits per write-enable lane. NB = DATA_WIDTH/BYTE_WIDTH.
- OUT_REG, 0: 0 gives 1-cycle response latency; 1 adds an output register, giving 2 cycles.
- WR_MODE, 0: 0 = READ_FIRST (a write returns the old word); 1 = WRITE_FIRST (a write returns the merged new word).
- CLEAR_ON_RESET, 1: 1 zeroes the whole array automatically after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  NB  byte enables; ignored on reads.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  DATA_WIDTH  response data; holds its value between pulses.
- rsp_err  out  1  qualified by rsp_valid; 1 = address ≥ DEPTH.
- clr_start  in  1  pulse requesting a full-array clear.
- busy  out  1  clear in progress.

## Operation
- FSM states: IDLE and CLEAR.
- Reset:
  - During reset, the FSM goes to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE.
  - The clear address counter resets to 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 while reset is asserted.
  - busy=CLEAR_ON_RESET while reset is asserted.
- CLEAR state:
  - Writes 0 to one address per cycle, counting 0 up to DEPTH-1.
  - busy=1 and req_ready=0 throughout.
  - After writing DEPTH-1, the FSM goes to IDLE on the next edge and busy falls.
  - A full clear takes exactly DEPTH cycles.
- IDLE state:
  - req_ready = ~clr_start.
  - clr_start=1 moves the FSM to CLEAR and the counter to 0. Any request in the same cycle is not accepted (clear wins).
  - clr_start while busy is ignored.
- A request is accepted on an edge where req_valid & req_ready.
- Write handling:
  - Only lanes with req_be[i]=1 are updated.
  - req_be=0 is a legal no-op write that still produces a response.
- Response data:
  - Read: the stored word.
  - Write, WR_MODE=0: the word before the write.
  - Write, WR_MODE=1: the merged word after the write.
- Out-of-range addresses (req_addr ≥ DEPTH):
  - The memory is not modified.
  - rsp_rdata=0 and rsp_err=1 on the corresponding response.
- Throughput: one request per cycle, with no response backpressure.
- Responses already in flight when a clear starts are still delivered, carrying the data read before the clear.
- Async reset during CLEAR aborts it. With CLEAR_ON_RESET=1, the clear restarts from address 0. In-flight responses are discarded.

## Timing
- Request accepted at edge N:
  - OUT_REG=0: rsp_valid=1 in the cycle after edge N; data is visible from edge N.
  - OUT_REG=1: rsp_valid=1 in the cycle after edge N+1.
- Back-to-back accepts give back-to-back rsp_valid pulses in the same order.
- Write then read of the same address on consecutive cycles: the read returns the written data (no hazard window).
- req_ready is combinational from state and clr_start only; it never depends on req_valid.
- With CLEAR_ON_RESET=1, first acceptance is possible at edge DEPTH+1 after reset release.

## Test plan
- Reset, DEPTH=16, CLEAR_ON_RESET=1 → busy=1 for 16 cycles, req_ready=0; then reading every address returns 0x00000000, rsp_err=0.
- Write 0xDEADBEEF to addr 3 with be=4'b1111, then write 0x11223344 to addr 3 with be=4'b0101, then read addr 3 → 0xDE22BE44; responses on three consecutive cycles with OUT_REG=0, delayed by one more cycle with OUT_REG=1.
- WR_MODE=0 vs 1: addr 5 holds 0xAAAAAAAA; write 0x55555555 with be=4'b1111 → rsp_rdata is 0xAAAAAAAA in mode 0 and 0x55555555 in mode 1.
- DEPTH=12, ADDR_WIDTH=4: write to addr 13, then read addr 13 → both responses have rsp_err=1 and rdata=0; memory at addresses 0–11 is unchanged.
- clr_start asserted together with req_valid while IDLE → request not accepted, busy=1 for DEPTH cycles; a read issued just before clr_start still returns its pre-clear data.
- rst_n pulsed low at clear cycle 7 → clear restarts at address 0; busy stays high for a full 16 cycles after release.
